node_port_tx: RTL and testbench

- Transmit-side endpoint of the inter-node link. It accepts flits from local router logic over a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and drives the upstream side of node_port: flit and enable out, ack in.
- Holds each flit stable until the downstream node acknowledges it, so link backpressure propagates to local logic through in_ready.
- One instance per output port of a node.

---
 rtl/noc_types_pkg.sv | 12 +
 rtl/node_port_tx_if.sv | 17 +
 rtl/node_port_tx.sv | 105 ++++++++++
 tb/tb_node_port_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_types_pkg.sv
// ============================================================================
// Module      : noc_types
// Description : Shared flit type for the inter-node link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_types;
    typedef logic [31:0] flit_t;
endpackage

`default_nettype wire

// File: rtl/node_port_tx_if.sv
// ============================================================================
// Module      : node_port
// Description : Inter-node link bundle: flit/enable toward downstream, ack back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface node_port;
    noc_types::flit_t flit;
    logic             enable;
    logic             ack;

    modport up   (output flit, output enable, input  ack);
    modport down (input  flit, input  enable, output ack);
endinterface

`default_nettype wire

// File: rtl/node_port_tx.sv
// ============================================================================
// Module      : node_port_tx
// Description : Transmit endpoint: valid/ready intake, DEPTH-entry FIFO, and a
//               hold-until-ack link driver with a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module node_port_tx #(
    parameter int DEPTH   = 4,
    parameter int STALL_W = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire noc_types::flit_t           in_flit,
    input  wire logic                       in_valid,
    output logic                            in_ready,
    node_port.up                            up,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic [STALL_W-1:0]              stall_cnt
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    noc_types::flit_t   r_mem [DEPTH];
    logic [c_aw-1:0]    r_wptr;
    logic [c_aw-1:0]    r_rptr;
    logic [c_cw-1:0]    r_count;
    state_t             r_state;
    noc_types::flit_t   r_flit;
    logic               r_ready;
    logic [STALL_W-1:0] r_stall;

    logic               w_push;
    logic               w_pop;
    logic [c_cw-1:0]    w_count_nxt;
    logic [c_aw-1:0]    w_rptr_nxt;
    noc_types::flit_t   w_head_nxt;

    assign w_push = in_valid && r_ready;
    assign w_pop  = (r_state == ST_SEND) && up.ack;

    always_comb begin
        w_count_nxt = r_count + c_cw'(w_push) - c_cw'(w_pop);
        w_rptr_nxt  = r_rptr + c_aw'(w_pop);
        // The next head may be the flit being written this very edge.
        if (w_push && (w_rptr_nxt == r_wptr)) begin
            w_head_nxt = in_flit;
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= ST_IDLE;
            r_flit  <= '0;
            r_ready <= 1'b0;
            r_stall <= '0;
        end else begin
            r_wptr  <= r_wptr + c_aw'(w_push);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_cw'(DEPTH));

            case (r_state)
                ST_IDLE: if (w_push)             r_state <= ST_SEND;
                ST_SEND: if (w_count_nxt == '0)  r_state <= ST_IDLE;
                default:                         r_state <= ST_IDLE;
            endcase

            r_flit <= (w_count_nxt != '0) ? w_head_nxt : '0;

            if ((r_state != ST_SEND) || w_pop) begin
                r_stall <= '0;
            end else if (r_stall != {STALL_W{1'b1}}) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign in_ready  = r_ready;
    assign up.flit   = r_flit;
    assign up.enable = (r_state == ST_SEND);
    assign count     = r_count;
    assign stall_cnt = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_node_port_tx.sv
// ============================================================================
// Module      : tb_node_port_tx
// Description : Self-checking bench for node_port_tx against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_node_port_tx;

    localparam int DEPTH   = 4;
    localparam int STALL_W = 4;
    localparam int SMAX    = (1 << STALL_W) - 1;

    logic             clk;
    logic             rst_n;
    noc_types::flit_t in_flit;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       count;
    logic [STALL_W-1:0] stall_cnt;

    node_port link ();

    node_port_tx #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .up        (link.up),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: FIFO contents as a queue, plus stall count and ready-arm flag.
    noc_types::flit_t q[$];
    noc_types::flit_t outq[$];
    int               m_stall;
    bit               m_armed;

    function automatic bit m_ready();
        return m_armed && (q.size() < DEPTH);
    endfunction

    task automatic tick();
        bit en, push, pop;
        noc_types::flit_t dummy;
        en   = (q.size() != 0);
        push = in_valid && m_ready();
        pop  = en && link.ack;
        if (pop) outq.push_back(q[0]);
        @(posedge clk);
        if (pop) dummy = q.pop_front();
        if (push) q.push_back(in_flit);
        if (en && !pop) m_stall = (m_stall == SMAX) ? SMAX : m_stall + 1;
        else            m_stall = 0;
        m_armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_stall = 0;
        m_armed = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; link.ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (link.enable !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0 || link.flit !== '0 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_hold: en=%b cnt=%0d rdy=%b flit=%h stall=%0d expected 0 0 0 0 0",
                     link.enable, count, in_ready, link.flit, stall_cnt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (link.enable !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_release: en=%b cnt=%0d rdy=%b stall=%0d expected 0 0 1 0",
                     link.enable, count, in_ready, stall_cnt);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_flit = 32'hA000_0001; link.ack = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (link.enable !== 1'b1 || link.flit !== 32'hA000_0001 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_out: en=%b flit=%h cnt=%0d expected 1 a0000001 1", link.enable, link.flit, count);
        end
        tick();
        checks++;
        if (link.enable !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_drain: en=%b cnt=%0d expected 0 0", link.enable, count);
        end
    endtask

    task automatic test_fill();
        link.ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_flit = 32'hF000_0000 + i;
            checks++;
            if (in_ready !== (i < 4)) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b expected %b", i, in_ready, (i < 4));
            end
            tick();
        end
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || link.flit !== 32'hF000_0000 || link.enable !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: cnt=%0d rdy=%b flit=%h en=%b expected 4 0 f0000000 1",
                     count, in_ready, link.flit, link.enable);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (link.flit !== 32'hF000_0000 || stall_cnt !== STALL_W'(m_stall) || m_stall != 4 + i) begin
                errors++;
                $display("FAIL fill_stall[%0d]: flit=%h stall=%0d expected f0000000 %0d", i, link.flit, stall_cnt, 4 + i);
            end
            tick();
        end
    endtask

    task automatic test_drain_wrap();
        int k;
        int cyc;
        k = 4; cyc = 0;
        outq.delete();
        link.ack = 1'b1;
        while ((k < 8 || q.size() != 0) && cyc < 40) begin
            in_valid = (k < 8); in_flit = 32'hF000_0000 + k;
            checks++;
            if (count !== 3'(q.size()) || (q.size() != 0 && link.flit !== q[0]) || count > 3'd4) begin
                errors++;
                $display("FAIL drain_state: cnt=%0d flit=%h expected cnt=%0d", count, link.flit, q.size());
            end
            if (in_valid && m_ready()) begin
                tick(); k++;
            end else begin
                tick();
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc >= 40) begin
            errors++;
            $display("FAIL drain_timeout: cycles=%0d expected <40", cyc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outq.size() != 8 || outq[i] !== 32'hF000_0000 + i) begin
                errors++;
                $display("FAIL drain_order[%0d]: got %h (n=%0d) expected %h", i,
                         (i < outq.size()) ? outq[i] : 32'hx, outq.size(), 32'hF000_0000 + i);
            end
        end
    endtask

    task automatic test_full_concurrent();
        link.ack = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_flit = 32'hC000_0000 + i;
            tick();
        end
        link.ack = 1'b1; in_flit = 32'hC000_0004;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_pre: cnt=%0d rdy=%b expected 4 0", count, in_ready);
        end
        tick();
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || link.flit !== 32'hC000_0001) begin
            errors++;
            $display("FAIL fullpop_after: cnt=%0d rdy=%b flit=%h expected 3 1 c0000001", count, in_ready, link.flit);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || link.flit !== 32'hC000_0002 || q[2] !== 32'hC000_0004) begin
            errors++;
            $display("FAIL fullpop_push: cnt=%0d flit=%h expected 3 c0000002", count, link.flit);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (count !== 3'd0 || link.enable !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_drain: cnt=%0d en=%b expected 0 0", count, link.enable);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_flit  = $urandom;
            link.ack = ($urandom_range(0, 2) == 0);
            checks++;
            if (count !== 3'(q.size()) || link.enable !== (q.size() != 0) || in_ready !== m_ready()
                || stall_cnt !== STALL_W'(m_stall) || (q.size() != 0 && link.flit !== q[0])) begin
                errors++;
                $display("FAIL random[%0d]: cnt=%0d en=%b rdy=%b stall=%0d flit=%h expected cnt=%0d en=%b rdy=%b stall=%0d flit=%h",
                         i, count, link.enable, in_ready, stall_cnt, link.flit, q.size(), (q.size() != 0),
                         m_ready(), m_stall, (q.size() != 0) ? q[0] : 32'h0);
            end
            tick();
        end
        in_valid = 1'b0; link.ack = 1'b1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_stall_sat();
        link.ack = 1'b0; in_valid = 1'b1; in_flit = 32'h5A5A_5A5A;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (stall_cnt !== STALL_W'(SMAX) || m_stall != SMAX || link.flit !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL stall_sat: stall=%0d flit=%h expected %0d 5a5a5a5a", stall_cnt, link.flit, SMAX);
        end
        link.ack = 1'b1;
        tick();
        checks++;
        if (stall_cnt !== '0 || link.enable !== 1'b0) begin
            errors++;
            $display("FAIL stall_clear: stall=%0d en=%b expected 0 0", stall_cnt, link.enable);
        end
    endtask

    task automatic test_async_reset();
        link.ack = 1'b0; in_valid = 1'b1;
        in_flit = 32'hD000_0000; tick();
        in_flit = 32'hD000_0001; tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL areset_pre: cnt=%0d expected 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (link.enable !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: en=%b cnt=%0d rdy=%b expected 0 0 0", link.enable, count, in_ready);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        link.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (link.enable !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || link.flit !== '0) begin
                errors++;
                $display("FAIL areset_after[%0d]: en=%b cnt=%0d rdy=%b flit=%h expected 0 0 1 0",
                         i, link.enable, count, in_ready, link.flit);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; link.ack = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_drain_wrap();
        test_full_concurrent();
        test_random();
        test_stall_sat();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
